apb_req_arbiter: RTL and testbench

- Two-requester round-robin scheduler in front of the APB master's control interface (transfer/read/write, address, data and strobe signals, with apb_done handshake).
- Requester 0 is the AXI4-lite bridge; requester 1 is an internal config/DMA engine.
- Serialises single APB transactions, returns read data and the error flag to the granted requester, and aborts with error if the master never completes.

---
 rtl/apb_req_arbiter_pkg.sv | 19 +
 rtl/apb_req_arbiter_rr_pick.sv | 27 ++
 rtl/apb_req_arbiter.sv | 175 +++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_arbiter_pkg.sv
// apb_arb_pkg: shared definitions for the two-requester APB arbiter.
//   arb_state_t            - arbiter FSM state encoding
//   REQ_AXI / REQ_CFG      - requester indices (AXI4-lite bridge / config-DMA engine)
//   DEFAULT_TIMEOUT_CYCLES - default WAIT budget before abort
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic REQ_AXI = 1'b0;
  localparam logic REQ_CFG = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// apb_rr_pick: combinational two-way round-robin select.
//   valid[1:0]  in  - request lines (bit N = requester N)
//   last_grant  in  - index granted most recently
//   grant_idx   out - winning requester index
//   grant_any   out - at least one requester is valid
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_idx,
  output logic       grant_any
);

  always_comb begin
    grant_any = |valid;
    if (valid == 2'b11) begin
      // Tie: the requester that was not served last time wins.
      grant_idx = (last_grant == REQ_AXI) ? REQ_CFG : REQ_AXI;
    end else if (valid[1]) begin
      grant_idx = REQ_CFG;
    end else begin
      grant_idx = REQ_AXI;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin scheduler of two requesters onto the APB
// master control interface. One transaction at a time; read data and the
// error flag are returned to the granted requester with a done pulse.
// A transaction whose master never completes is aborted with error.
//   PCLK/PRESETn            - clock, asynchronous active-low reset
//   reqN_valid/write/addr/wdata/strb  in  - requester N request (held until done)
//   reqN_done/rdata/err     out - completion pulse, read data, error
//   transfer/read/write     out - command to APB master (transfer = start pulse)
//   apb_waddr/apb_raddr/apb_wdata/PSTRB out - address, data, strobes to master
//   apb_done/apb_rdata/err_flag in - master completion, read data, slave error
//   abort                   out - one-cycle pulse on timeout
//   busy                    out - arbiter not idle
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req0_valid,
  input  logic                    req0_write,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_strb,
  output logic                    req0_done,
  output logic [DATA_WIDTH-1:0]   req0_rdata,
  output logic                    req0_err,
  input  logic                    req1_valid,
  input  logic                    req1_write,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_strb,
  output logic                    req1_done,
  output logic [DATA_WIDTH-1:0]   req1_rdata,
  output logic                    req1_err,
  output logic                    transfer,
  output logic                    read,
  output logic                    write,
  output logic [ADDR_WIDTH-1:0]   apb_waddr,
  output logic [ADDR_WIDTH-1:0]   apb_raddr,
  output logic [DATA_WIDTH-1:0]   apb_wdata,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    apb_done,
  input  logic [DATA_WIDTH-1:0]   apb_rdata,
  input  logic                    err_flag,
  output logic                    abort,
  output logic                    busy
);

  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t             state;
  logic                   last_grant;
  logic                   grant_l;
  logic [CNT_WIDTH-1:0]   cnt;

  logic                   grant_idx;
  logic                   grant_any;
  logic                   sel_write;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_strb;
  logic                   timeout_hit;
  logic [DATA_WIDTH-1:0]  cap_rdata;
  logic                   cap_err;

  apb_rr_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  always_comb begin
    if (grant_idx == REQ_CFG) begin
      sel_write = req1_write;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
      sel_strb  = req1_strb;
    end else begin
      sel_write = req0_write;
      sel_addr  = req0_addr;
      sel_wdata = req0_wdata;
      sel_strb  = req0_strb;
    end
  end

  // apb_done has priority over the timeout when both land in the same cycle.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
    cap_rdata   = apb_done ? apb_rdata : '0;
    cap_err     = apb_done ? err_flag  : 1'b1;
  end

  // Outputs are registered for the state being entered, so transfer is
  // high exactly during ISSUE and done/abort exactly during RESP.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= REQ_CFG;
      grant_l    <= REQ_AXI;
      cnt        <= '0;
      transfer   <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      apb_waddr  <= '0;
      apb_raddr  <= '0;
      apb_wdata  <= '0;
      PSTRB      <= '0;
      abort      <= 1'b0;
      busy       <= 1'b0;
      req0_done  <= 1'b0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_done  <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
    end else begin
      transfer  <= 1'b0;
      abort     <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            grant_l   <= grant_idx;
            transfer  <= 1'b1;
            read      <= ~sel_write;
            write     <= sel_write;
            apb_waddr <= sel_addr;
            apb_raddr <= sel_addr;
            apb_wdata <= sel_wdata;
            PSTRB     <= sel_write ? sel_strb : '0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (apb_done || timeout_hit) begin
            abort <= ~apb_done;
            read  <= 1'b0;
            write <= 1'b0;
            if (grant_l == REQ_CFG) begin
              req1_done  <= 1'b1;
              req1_rdata <= cap_rdata;
              req1_err   <= cap_err;
            end else begin
              req0_done  <= 1'b1;
              req0_rdata <= cap_rdata;
              req0_err   <= cap_err;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        RESP: begin
          last_grant <= grant_l;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic [3:0]  req0_strb = '0;
  logic        req0_done, req0_err;
  logic [31:0] req0_rdata;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic [3:0]  req1_strb = '0;
  logic        req1_done, req1_err;
  logic [31:0] req1_rdata;
  logic        transfer, read, write, abort, busy;
  logic [31:0] apb_waddr, apb_raddr, apb_wdata;
  logic [3:0]  PSTRB;
  logic        apb_done = 1'b0, err_flag = 1'b0;
  logic [31:0] apb_rdata = '0;

  apb_req_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(8)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .transfer(transfer), .read(read), .write(write),
    .apb_waddr(apb_waddr), .apb_raddr(apb_raddr), .apb_wdata(apb_wdata),
    .PSTRB(PSTRB), .apb_done(apb_done), .apb_rdata(apb_rdata),
    .err_flag(err_flag), .abort(abort), .busy(busy)
  );

  initial forever #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } cmd_t;

  typedef struct {
    logic        idx;
    logic [31:0] rdata;
    logic        err;
    logic        abrt;
    int          lat;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  // Master model configuration.
  logic        m_never = 1'b0;
  int          m_delay = 3;
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  // APB master model: answers each transfer m_delay cycles later.
  initial forever begin
    @(negedge PCLK);
    if (PRESETn && transfer && !m_never) begin
      repeat (m_delay) @(negedge PCLK);
      apb_done  = 1'b1;
      apb_rdata = m_rdata;
      err_flag  = m_err;
      @(negedge PCLK);
      apb_done  = 1'b0;
      apb_rdata = '0;
      err_flag  = 1'b0;
    end
  end

  // Monitor: compares master commands and requester responses against the queues.
  initial begin
    logic prev_xfer;
    int   xfer_cyc;
    cmd_t c;
    rsp_t r;
    prev_xfer = 1'b0;
    xfer_cyc  = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        prev_xfer = 1'b0;
      end else begin
        if (prev_xfer) check("transfer_pulse", transfer, 0);
        if (transfer) begin
          check("cmd_expected", cmd_q.size() != 0, 1);
          if (cmd_q.size() != 0) begin
            c = cmd_q.pop_front();
            check("cmd_write", write, c.wr);
            check("cmd_read", read, !c.wr);
            check("cmd_waddr", apb_waddr, c.addr);
            check("cmd_raddr", apb_raddr, c.addr);
            check("cmd_wdata", apb_wdata, c.wdata);
            check("cmd_pstrb", PSTRB, c.strb);
            check("cmd_busy", busy, 1);
          end
          xfer_cyc = cyc;
        end
        if (abort) check("abort_with_done", req0_done | req1_done, 1);
        if (req0_done || req1_done) begin
          done_cnt++;
          check("single_done", req0_done & req1_done, 0);
          check("rsp_expected", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            check("rsp_idx", req1_done, r.idx);
            check("rsp_rdata", req1_done ? req1_rdata : req0_rdata, r.rdata);
            check("rsp_err", req1_done ? req1_err : req0_err, r.err);
            check("rsp_abort", abort, r.abrt);
            check("rsp_latency", cyc - xfer_cyc, r.lat);
            check("rsp_rw_low", {read, write}, 0);
          end
        end
        prev_xfer = transfer;
      end
    end
  end

  task automatic set_req(input logic idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    if (idx) begin
      req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_strb = strb;
    end else begin
      req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_strb = strb;
    end
  endtask

  task automatic run_single(input logic idx, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic exp_abort, input int exp_lat);
    logic seen;
    cmd_q.push_back('{wr, addr, wdata, wr ? strb : 4'h0});
    rsp_q.push_back('{idx, exp_rdata, exp_err, exp_abort, exp_lat});
    @(negedge PCLK);
    set_req(idx, wr, addr, wdata, strb);
    if (idx) req1_valid = 1'b1; else req0_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge PCLK);
      if (idx ? req1_done : req0_done) seen = 1'b1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("done_seen", seen, 1);
    @(negedge PCLK);
  endtask

  // Both requesters valid; grants must alternate starting with requester 0.
  task automatic run_both(input int n);
    int t0, t1, c0, c1;
    t0 = (n + 1) / 2;
    t1 = n / 2;
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < n; k++) begin
      if (k % 2 == 0) cmd_q.push_back('{1'b1, 32'h40, 32'h1111_0000, 4'h3});
      else            cmd_q.push_back('{1'b0, 32'h140, 32'h2222_0000, 4'h0});
      rsp_q.push_back('{(k % 2 == 1), m_rdata, m_err, 1'b0, m_delay + 1});
    end
    @(negedge PCLK);
    set_req(1'b0, 1'b1, 32'h40, 32'h1111_0000, 4'h3);
    set_req(1'b1, 1'b0, 32'h140, 32'h2222_0000, 4'hC);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 100 * n && (c0 < t0 || c1 < t1); i++) begin
      @(negedge PCLK);
      if (req0_done) begin c0++; if (c0 >= t0) req0_valid = 1'b0; end
      if (req1_done) begin c1++; if (c1 >= t1) req1_valid = 1'b0; end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("both_cnt0", c0, t0);
    check("both_cnt1", c1, t1);
    @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    int   d_before;
    logic seen;

    // Reset state, during and after reset.
    repeat (2) @(negedge PCLK);
    check("rst_ctl", {transfer, read, write, abort, busy, req0_done, req1_done, req0_err, req1_err}, 0);
    check("rst_addr", {apb_waddr, apb_raddr}, 0);
    check("rst_data", {apb_wdata, PSTRB}, 0);
    check("rst_rdata", {req0_rdata, req1_rdata}, 0);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    check("idle_busy", busy, 0);
    check("idle_transfer", transfer, 0);

    // Write from requester 0 alone, done 3 cycles after transfer.
    m_never = 1'b0; m_delay = 3; m_rdata = 32'h0; m_err = 1'b0;
    run_single(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0, 4);

    // Read from requester 1 alone; strobes supplied but must not reach PSTRB.
    m_rdata = 32'h1234_5678;
    run_single(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 4);

    // Contention: four transactions, order 0,1,0,1.
    m_delay = 2; m_rdata = 32'h55AA_55AA;
    run_both(4);

    // Timeout: master never answers; abort in the 9th cycle after ISSUE.
    m_never = 1'b1;
    run_single(1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 9);
    d_before = done_cnt;
    apb_done = 1'b1; apb_rdata = 32'hBAD0_BAD0; err_flag = 1'b1;
    @(negedge PCLK);
    apb_done = 1'b0; apb_rdata = '0; err_flag = 1'b0;
    repeat (3) @(negedge PCLK);
    check("late_done_busy", busy, 0);
    check("late_done_ignored", done_cnt, d_before);

    // apb_done exactly in the timeout cycle: done wins, no abort.
    m_never = 1'b0; m_delay = 8; m_rdata = 32'hCAFE_F00D; m_err = 1'b1;
    run_single(1'b0, 1'b0, 32'h0000_0024, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 9);

    // Reset during WAIT of a requester 1 transaction.
    m_never = 1'b1;
    cmd_q.push_back('{1'b0, 32'h300, 32'h0, 4'h0});
    @(negedge PCLK);
    set_req(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    req1_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      if (transfer) seen = 1'b1;
    end
    check("rst_wait_xfer_seen", seen, 1);
    repeat (3) @(negedge PCLK);
    check("rst_wait_busy_before", busy, 1);
    d_before = done_cnt;
    PRESETn = 1'b0;
    #1;
    check("async_rst_ctl", {transfer, read, write, abort, busy, req0_done, req1_done, req0_err, req1_err}, 0);
    check("async_rst_addr", {apb_waddr, apb_raddr}, 0);
    check("async_rst_data", {apb_wdata, PSTRB}, 0);
    check("async_rst_rdata", {req0_rdata, req1_rdata}, 0);
    req1_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    check("rst_no_done", done_cnt, d_before);

    // After reset requester 0 must win the first tie.
    m_never = 1'b0; m_delay = 1; m_rdata = 32'h0BAD_F00D; m_err = 1'b0;
    run_both(2);

    repeat (3) @(negedge PCLK);
    check("cmd_q_empty", cmd_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    check("done_total", done_cnt, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
